// File: rtl/rs_alu.sv
// Integer ALU reservation station: buffers dispatched ops until both operands
// resolve from the ALU/LSB result broadcasts, then issues one ready op per cycle.
module rs_alu #(
  parameter int RS_SIZE      = 8,
  parameter int RS_SIZE_BIT  = 3,
  parameter int ROB_SIZE_BIT = 4,
  parameter int RS_TYPE_BIT  = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    dec_valid,
  input  logic [RS_TYPE_BIT-1:0]  dec_type,
  input  logic [ROB_SIZE_BIT-1:0] dec_rob_id,
  input  logic                    dec_r1_busy,
  input  logic [ROB_SIZE_BIT-1:0] dec_r1_tag,
  input  logic [31:0]             dec_r1_val,
  input  logic                    dec_r2_busy,
  input  logic [ROB_SIZE_BIT-1:0] dec_r2_tag,
  input  logic [31:0]             dec_r2_val,
  output logic                    rs_full,
  input  logic                    alu_cdb_valid,
  input  logic [ROB_SIZE_BIT-1:0] alu_cdb_rob_id,
  input  logic [31:0]             alu_cdb_val,
  input  logic                    lsb_cdb_valid,
  input  logic [ROB_SIZE_BIT-1:0] lsb_cdb_rob_id,
  input  logic [31:0]             lsb_cdb_val,
  output logic                    alu_input,
  output logic [RS_TYPE_BIT-1:0]  arith_type,
  output logic [31:0]             r1_val,
  output logic [31:0]             r2_val,
  output logic [ROB_SIZE_BIT-1:0] inst_rob_id
);

  logic [RS_SIZE-1:0]      r_busy, r_q1_busy, r_q2_busy;
  logic [RS_TYPE_BIT-1:0]  r_type   [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] r_rob_id [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] r_q1_tag [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] r_q2_tag [RS_SIZE];
  logic [31:0]             r_v1     [RS_SIZE];
  logic [31:0]             r_v2     [RS_SIZE];

  logic                    r_alu_input;
  logic [RS_TYPE_BIT-1:0]  r_arith_type;
  logic [31:0]             r_r1_val, r_r2_val;
  logic [ROB_SIZE_BIT-1:0] r_inst_rob_id;

  logic [RS_SIZE-1:0]      w_ready;
  logic                    w_free_found, w_issue_found, w_insert;
  logic [RS_SIZE_BIT-1:0]  w_free_idx, w_issue_idx;
  logic                    w_ins_q1_busy, w_ins_q2_busy;
  logic [31:0]             w_ins_v1, w_ins_v2;

  assign w_ready  = r_busy & ~r_q1_busy & ~r_q2_busy;
  assign rs_full  = &r_busy;
  assign w_insert = dec_valid && !rs_full;

  // Scanning downward leaves the lowest matching index as the final winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_free_found  = 1'b0;
    w_free_idx    = '0;
    w_issue_found = 1'b0;
    w_issue_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = RS_SIZE_BIT'(i);
      end
      if (w_ready[i]) begin
        w_issue_found = 1'b1;
        w_issue_idx   = RS_SIZE_BIT'(i);
      end
    end
  end

  // Same-cycle bypass for the incoming op; the ALU broadcast wins a tag tie.
  always_comb begin
    w_ins_q1_busy = dec_r1_busy;
    w_ins_v1      = dec_r1_val;
    w_ins_q2_busy = dec_r2_busy;
    w_ins_v2      = dec_r2_val;
    if (dec_r1_busy) begin
      if (alu_cdb_valid && alu_cdb_rob_id == dec_r1_tag) begin
        w_ins_q1_busy = 1'b0;
        w_ins_v1      = alu_cdb_val;
      end else if (lsb_cdb_valid && lsb_cdb_rob_id == dec_r1_tag) begin
        w_ins_q1_busy = 1'b0;
        w_ins_v1      = lsb_cdb_val;
      end
    end
    if (dec_r2_busy) begin
      if (alu_cdb_valid && alu_cdb_rob_id == dec_r2_tag) begin
        w_ins_q2_busy = 1'b0;
        w_ins_v2      = alu_cdb_val;
      end else if (lsb_cdb_valid && lsb_cdb_rob_id == dec_r2_tag) begin
        w_ins_q2_busy = 1'b0;
        w_ins_v2      = lsb_cdb_val;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && rob_clear)) begin
      // NOTE: payload arrays are left unreset on purpose; r_busy/q_busy gate every read of them.
      r_busy        <= '0;
      r_q1_busy     <= '0;
      r_q2_busy     <= '0;
      r_alu_input   <= 1'b0;
      r_arith_type  <= '0;
      r_r1_val      <= '0;
      r_r2_val      <= '0;
      r_inst_rob_id <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && r_q1_busy[i]) begin
          if (alu_cdb_valid && alu_cdb_rob_id == r_q1_tag[i]) begin
            r_q1_busy[i] <= 1'b0;
            r_v1[i]      <= alu_cdb_val;
          end else if (lsb_cdb_valid && lsb_cdb_rob_id == r_q1_tag[i]) begin
            r_q1_busy[i] <= 1'b0;
            r_v1[i]      <= lsb_cdb_val;
          end
        end
        if (r_busy[i] && r_q2_busy[i]) begin
          if (alu_cdb_valid && alu_cdb_rob_id == r_q2_tag[i]) begin
            r_q2_busy[i] <= 1'b0;
            r_v2[i]      <= alu_cdb_val;
          end else if (lsb_cdb_valid && lsb_cdb_rob_id == r_q2_tag[i]) begin
            r_q2_busy[i] <= 1'b0;
            r_v2[i]      <= lsb_cdb_val;
          end
        end
      end

      if (w_issue_found) begin
        r_busy[w_issue_idx] <= 1'b0;
        r_alu_input         <= 1'b1;
        r_arith_type        <= r_type[w_issue_idx];
        r_r1_val            <= r_v1[w_issue_idx];
        r_r2_val            <= r_v2[w_issue_idx];
        r_inst_rob_id       <= r_rob_id[w_issue_idx];
      end else begin
        r_alu_input   <= 1'b0;
        r_arith_type  <= '0;
        r_r1_val      <= '0;
        r_r2_val      <= '0;
        r_inst_rob_id <= '0;
      end

      // The free slot was free in registered state, so it never collides with the issued one.
      if (w_insert) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_type[w_free_idx]    <= dec_type;
        r_rob_id[w_free_idx]  <= dec_rob_id;
        r_q1_busy[w_free_idx] <= w_ins_q1_busy;
        r_q1_tag[w_free_idx]  <= dec_r1_tag;
        r_v1[w_free_idx]      <= w_ins_v1;
        r_q2_busy[w_free_idx] <= w_ins_q2_busy;
        r_q2_tag[w_free_idx]  <= dec_r2_tag;
        r_v2[w_free_idx]      <= w_ins_v2;
      end
    end
  end

  assign alu_input   = r_alu_input;
  assign arith_type  = r_arith_type;
  assign r1_val      = r_r1_val;
  assign r2_val      = r_r2_val;
  assign inst_rob_id = r_inst_rob_id;

  a_no_dispatch_when_full: assert property (@(posedge clk_in) disable iff (rst_in)
    (rdy_in && !rob_clear && dec_valid) |-> !rs_full);

endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: directed scenarios plus random traffic, all checked against a
// slot-level behavioural model of the reservation station.
module tb_rs_alu;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear, dec_valid;
  logic [4:0]  dec_type;
  logic [3:0]  dec_rob_id, dec_r1_tag, dec_r2_tag;
  logic        dec_r1_busy, dec_r2_busy;
  logic [31:0] dec_r1_val, dec_r2_val;
  logic        rs_full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        alu_input;
  logic [4:0]  arith_type;
  logic [31:0] r1_val, r2_val;
  logic [3:0]  inst_rob_id;

  always #5 clk_in = ~clk_in;

  rs_alu dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .dec_valid(dec_valid), .dec_type(dec_type), .dec_rob_id(dec_rob_id),
    .dec_r1_busy(dec_r1_busy), .dec_r1_tag(dec_r1_tag), .dec_r1_val(dec_r1_val),
    .dec_r2_busy(dec_r2_busy), .dec_r2_tag(dec_r2_tag), .dec_r2_val(dec_r2_val),
    .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_val(lsb_cdb_val),
    .alu_input(alu_input), .arith_type(arith_type), .r1_val(r1_val), .r2_val(r2_val),
    .inst_rob_id(inst_rob_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: eight slots, an op waits until both operands are known.
  typedef struct {
    bit          busy;
    logic [4:0]  typ;
    logic [3:0]  rob;
    bit          q1b;
    logic [3:0]  q1t;
    logic [31:0] v1;
    bit          q2b;
    logic [3:0]  q2t;
    logic [31:0] v2;
  } slot_t;

  slot_t       m_slot [8];
  bit          m_ai;
  logic [4:0]  m_ty;
  logic [31:0] m_r1, m_r2;
  logic [3:0]  m_rob;

  function automatic bit m_full();
    for (int i = 0; i < 8; i++) if (!m_slot[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Returns {still_waiting, value} after looking at this cycle's broadcasts.
  function automatic logic [32:0] snoop(bit waiting, logic [3:0] tag, logic [31:0] val);
    if (waiting && alu_cdb_valid && alu_cdb_rob_id == tag) return {1'b0, alu_cdb_val};
    if (waiting && lsb_cdb_valid && lsb_cdb_rob_id == tag) return {1'b0, lsb_cdb_val};
    return {waiting, val};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_slot[i].busy = 1'b0;
    m_ai = 0; m_ty = '0; m_r1 = '0; m_r2 = '0; m_rob = '0;
  endtask

  task automatic model_step();
    slot_t nx [8];
    int iss = -1;
    int fr  = -1;
    logic [32:0] s;
    if (rst_in || (rdy_in && rob_clear)) begin
      model_clear();
    end else if (rdy_in) begin
      for (int i = 0; i < 8; i++) begin
        if (iss < 0 && m_slot[i].busy && !m_slot[i].q1b && !m_slot[i].q2b) iss = i;
        if (fr < 0 && !m_slot[i].busy) fr = i;
      end
      nx = m_slot;
      for (int i = 0; i < 8; i++) begin
        if (nx[i].busy) begin
          s = snoop(nx[i].q1b, nx[i].q1t, nx[i].v1); nx[i].q1b = s[32]; nx[i].v1 = s[31:0];
          s = snoop(nx[i].q2b, nx[i].q2t, nx[i].v2); nx[i].q2b = s[32]; nx[i].v2 = s[31:0];
        end
      end
      if (iss >= 0) begin
        m_ai = 1; m_ty = m_slot[iss].typ; m_r1 = m_slot[iss].v1;
        m_r2 = m_slot[iss].v2; m_rob = m_slot[iss].rob;
        nx[iss].busy = 1'b0;
      end else begin
        m_ai = 0; m_ty = '0; m_r1 = '0; m_r2 = '0; m_rob = '0;
      end
      if (dec_valid && fr >= 0) begin
        nx[fr].busy = 1'b1; nx[fr].typ = dec_type; nx[fr].rob = dec_rob_id;
        nx[fr].q1t = dec_r1_tag; nx[fr].q2t = dec_r2_tag;
        s = snoop(dec_r1_busy, dec_r1_tag, dec_r1_val); nx[fr].q1b = s[32]; nx[fr].v1 = s[31:0];
        s = snoop(dec_r2_busy, dec_r2_tag, dec_r2_val); nx[fr].q2b = s[32]; nx[fr].v2 = s[31:0];
      end
      m_slot = nx;
    end
  endtask

  task automatic tick();
    check("rs_full", rs_full, m_full());
    model_step();
    @(posedge clk_in);
    #1;
    check("alu_input", alu_input, m_ai);
    check("arith_type", arith_type, m_ty);
    check("r1_val", r1_val, m_r1);
    check("r2_val", r2_val, m_r2);
    check("inst_rob_id", inst_rob_id, m_rob);
    rst_in = 0; rob_clear = 0; dec_valid = 0; alu_cdb_valid = 0; lsb_cdb_valid = 0;
  endtask

  task automatic dispatch(input logic [4:0] ty, input logic [3:0] rob,
                          input bit b1, input logic [3:0] t1, input logic [31:0] v1,
                          input bit b2, input logic [3:0] t2, input logic [31:0] v2);
    dec_valid = 1; dec_type = ty; dec_rob_id = rob;
    dec_r1_busy = b1; dec_r1_tag = t1; dec_r1_val = v1;
    dec_r2_busy = b2; dec_r2_tag = t2; dec_r2_val = v2;
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; rob_clear = 0; dec_valid = 0; dec_type = '0; dec_rob_id = '0;
    dec_r1_busy = 0; dec_r1_tag = '0; dec_r1_val = '0;
    dec_r2_busy = 0; dec_r2_tag = '0; dec_r2_val = '0;
    alu_cdb_valid = 0; alu_cdb_rob_id = '0; alu_cdb_val = '0;
    lsb_cdb_valid = 0; lsb_cdb_rob_id = '0; lsb_cdb_val = '0;

    // Reset
    @(posedge clk_in); #1;
    model_clear();
    check("rst_alu_input", alu_input, 0);
    check("rst_rs_full", rs_full, 0);
    check("rst_r1_val", r1_val, 0);
    rst_in = 0;

    // Ready ADD issues one cycle after insertion
    dispatch(5'h00, 4'd3, 0, 4'd0, 32'd5, 0, 4'd0, 32'd7);
    tick();
    check("add_not_yet", alu_input, 0);
    tick();
    check("add_issue", alu_input, 1);
    check("add_r1", r1_val, 32'd5);
    check("add_r2", r2_val, 32'd7);
    check("add_rob", inst_rob_id, 4'd3);
    tick();
    check("add_done", alu_input, 0);

    // SUB waits on tag 2, woken by the ALU broadcast
    dispatch(5'h01, 4'd4, 1, 4'd2, 32'd0, 0, 4'd0, 32'd3);
    tick(); tick();
    check("sub_wait", alu_input, 0);
    alu_cdb_valid = 1; alu_cdb_rob_id = 4'd2; alu_cdb_val = 32'd100;
    tick();
    check("sub_wake_edge", alu_input, 0);
    tick();
    check("sub_issue", alu_input, 1);
    check("sub_r1", r1_val, 32'd100);

    // Same-cycle bypass from the LSB broadcast
    dispatch(5'h02, 4'd5, 0, 4'd0, 32'd1, 1, 4'd9, 32'd0);
    lsb_cdb_valid = 1; lsb_cdb_rob_id = 4'd9; lsb_cdb_val = 32'hDEAD;
    tick(); tick();
    check("byp_issue", alu_input, 1);
    check("byp_r2", r2_val, 32'hDEAD);

    // Fill all entries waiting on tag 1, then drain in index order
    for (int i = 0; i < 8; i++) begin
      dispatch(5'h04, 4'(i), 1, 4'd1, 32'd0, 0, 4'd0, 32'(i));
      tick();
    end
    check("fill_full", rs_full, 1);
    alu_cdb_valid = 1; alu_cdb_rob_id = 4'd1; alu_cdb_val = 32'h11;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("drain_valid", alu_input, 1);
      check("drain_order", inst_rob_id, 4'(i));
      if (i == 0) check("drain_full_drop", rs_full, 0);
    end
    tick();
    check("drain_end", alu_input, 0);

    // Flush discards pending entries
    for (int i = 0; i < 4; i++) begin
      dispatch(5'h06, 4'(8 + i), 1, 4'd6, 32'd0, 0, 4'd0, 32'd0);
      tick();
    end
    rob_clear = 1;
    tick();
    check("clr_alu_input", alu_input, 0);
    check("clr_rs_full", rs_full, 0);
    alu_cdb_valid = 1; alu_cdb_rob_id = 4'd6; alu_cdb_val = 32'h66;
    tick(); tick();
    check("clr_stale_tag", alu_input, 0);

    // Stall with a ready entry, then exactly one issue
    dispatch(5'h10, 4'd12, 0, 4'd0, 32'd1, 0, 4'd0, 32'd2);
    tick();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", alu_input, 0);
    end
    rdy_in = 1;
    tick();
    check("stall_issue", alu_input, 1);
    check("stall_rob", inst_rob_id, 4'd12);
    tick();
    check("stall_once", alu_input, 0);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      rdy_in      = ($urandom_range(0, 9) != 0);
      rst_in      = ($urandom_range(0, 199) == 0);
      rob_clear   = ($urandom_range(0, 49) == 0);
      dec_valid   = !m_full() && ($urandom_range(0, 1) == 1);
      dec_type    = 5'($urandom);
      dec_rob_id  = 4'($urandom);
      dec_r1_busy = ($urandom_range(0, 1) == 1);
      dec_r1_tag  = 4'($urandom_range(0, 3));
      dec_r1_val  = $urandom;
      dec_r2_busy = ($urandom_range(0, 2) == 0);
      dec_r2_tag  = 4'($urandom_range(0, 3));
      dec_r2_val  = $urandom;
      alu_cdb_valid  = ($urandom_range(0, 2) == 0);
      alu_cdb_rob_id = 4'($urandom_range(0, 3));
      alu_cdb_val    = $urandom;
      lsb_cdb_valid  = ($urandom_range(0, 2) == 0);
      lsb_cdb_rob_id = 4'($urandom_range(0, 3));
      lsb_cdb_val    = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
